// File: rtl/fp_add_issue_if.sv
// Issue/result interface of the fp_add_issue wrapper.
// master: FP scheduler / writeback side (offers ops, consumes results, flushes).
// slave : fp_add_issue itself.
// Signals: flush, in_valid/in_ready/in_sub/in_a/in_b/in_tag,
//          out_valid/out_ready/out_y/out_tag.
interface fp_add_issue_if #(
    parameter int W     = 32,
    parameter int TAG_W = 6
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             in_sub;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_y;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output flush, in_valid, in_sub, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_tag
    );

    modport slave (
        input  flush, in_valid, in_sub, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_tag
    );
endinterface

// File: rtl/fp_add_issue.sv
// fp_add      : fixed-latency IEEE add (normals, zeros, subnormals, RNE, overflow
//               to Inf). NaN/Inf operands give meaningless results. Ports: clk,
//               reset, en (load stage 0), a, b, y (valid ADD_LAT cycles after en).
// fp_add_issue: valid/ready issue wrapper around fp_add with a tag/valid pipe,
//               NaN/Inf patching and a credit-protected result FIFO. Ports: clk,
//               reset (sync, active-high), bus (fp_add_issue_if.slave).
module fp_add #(
    parameter int W       = 32,
    parameter int ADD_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    localparam int EW = (W == 64) ? 11 : 8;
    localparam int FW = W - 1 - EW;
    localparam int XW = FW + 4;     // hidden + fraction + guard/round/sticky
    localparam logic [EW-1:0] E_ONE  = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EW:0]   ER_ONE = {{EW{1'b0}}, 1'b1};

    logic [W-1:0]              big_s, sml_s, res_s;
    logic [EW-1:0]             eb_s, es_s, d_s, lz_s, sh_s;
    logic [XW-1:0]             mb_s, ms_s, mal_s, norm_s;
    logic [XW:0]               sum_s;
    logic [EW:0]               er_s;
    logic [FW+1:0]             mant_s;
    logic [FW-1:0]             frac_s;
    logic [ADD_LAT-1:0][W-1:0] pipe_r;

    // Align, add/subtract magnitudes, normalise and round one result.
    always_comb begin
        // Larger magnitude first so the subtraction never goes negative.
        if (b[W-2:0] > a[W-2:0]) begin
            big_s = b;
            sml_s = a;
        end else begin
            big_s = a;
            sml_s = b;
        end
        // Subnormals share the exponent of the smallest normal.
        eb_s  = (big_s[W-2:FW] == {EW{1'b0}}) ? E_ONE : big_s[W-2:FW];
        es_s  = (sml_s[W-2:FW] == {EW{1'b0}}) ? E_ONE : sml_s[W-2:FW];
        mb_s  = {|big_s[W-2:FW], big_s[FW-1:0], 3'b000};
        ms_s  = {|sml_s[W-2:FW], sml_s[FW-1:0], 3'b000};
        d_s   = eb_s - es_s;
        // Bits shifted out collapse into the sticky LSB.
        mal_s = (ms_s >> d_s) | {{(XW-1){1'b0}}, |(ms_s & ~({XW{1'b1}} << d_s))};
        if (big_s[W-1] == sml_s[W-1]) begin
            sum_s = {1'b0, mb_s} + {1'b0, mal_s};
        end else begin
            sum_s = {1'b0, mb_s} - {1'b0, mal_s};
        end
        lz_s = EW'(XW);
        for (int i = 0; i < XW; i++) begin
            if (sum_s[i]) begin
                lz_s = EW'(XW - 1 - i);
            end else begin
                lz_s = lz_s;
            end
        end
        // Never normalise below the minimum exponent: that yields a subnormal.
        sh_s = (lz_s < (eb_s - E_ONE)) ? lz_s : (eb_s - E_ONE);
        if (sum_s[XW]) begin
            norm_s = {sum_s[XW:2], sum_s[1] | sum_s[0]};
            er_s   = {1'b0, eb_s} + ER_ONE;
        end else begin
            norm_s = sum_s[XW-1:0] << sh_s;
            er_s   = {1'b0, eb_s} - {1'b0, sh_s};
            er_s   = norm_s[XW-1] ? er_s : {(EW+1){1'b0}};
        end
        // Round to nearest, ties to even.
        mant_s = {1'b0, norm_s[XW-1:3]}
               + {{(FW+1){1'b0}}, norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3])};
        if (mant_s[FW+1]) begin
            er_s   = er_s + ER_ONE;
            frac_s = mant_s[FW:1];
        end else if ((er_s == {(EW+1){1'b0}}) && mant_s[FW]) begin
            er_s   = ER_ONE;        // subnormal rounded up into the normal range
            frac_s = mant_s[FW-1:0];
        end else begin
            frac_s = mant_s[FW-1:0];
        end
        if (sum_s == {(XW+1){1'b0}}) begin
            res_s = {big_s[W-1] & sml_s[W-1], {(W-1){1'b0}}};
        end else if (er_s >= {1'b0, {EW{1'b1}}}) begin
            res_s = {big_s[W-1], {EW{1'b1}}, {FW{1'b0}}};
        end else begin
            res_s = {big_s[W-1], er_s[EW-1:0], frac_s};
        end
    end

    // Fixed-latency result pipe; stage 0 only loads on an issued op.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_r <= {(ADD_LAT*W){1'b0}};
        end else begin
            pipe_r[0] <= en ? res_s : pipe_r[0];
            for (int i = 1; i < ADD_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign y = pipe_r[ADD_LAT-1];
endmodule

module fp_add_issue_chk (
    input logic clk,
    input logic reset,
    input logic wr,
    input logic full
);
    // A retire into a full result FIFO means the credit accounting is broken.
    assert property (@(posedge clk) disable iff (reset) !(wr && full));
endmodule

module fp_add_issue #(
    parameter int W       = 32,
    parameter int ADD_LAT = 2,
    parameter int TAG_W   = 6,
    parameter int Q_DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    fp_add_issue_if.slave bus
);
    localparam int EW = (W == 64) ? 11 : 8;
    localparam int FW = W - 1 - EW;
    localparam int PW = $clog2(Q_DEPTH);
    localparam int CW = $clog2(Q_DEPTH + 1);
    localparam logic [W-1:0] CNAN = (W == 64) ? W'(64'h7ff8_0000_0000_0000)
                                              : W'(32'h7fc0_0000);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [CW-1:0]                 cnt_r;
    logic                          accept_s, pop_s, clear_s, wr_s, full_s;
    logic                          a_nan_s, b_nan_s, a_inf_s, b_inf_s, eb_s;
    logic                          spec_s;
    logic [W-1:0]                  sval_s, fp_b_s, fp_y_s, wr_y_s;
    logic [ADD_LAT-1:0]            p_valid_r, p_spec_r;
    logic [ADD_LAT-1:0][TAG_W-1:0] p_tag_r;
    logic [ADD_LAT-1:0][W-1:0]     p_sval_r;
    logic [W-1:0]                  q_y_r   [Q_DEPTH];
    logic [TAG_W-1:0]              q_tag_r [Q_DEPTH];
    logic [PW:0]                   wr_ptr_r, rd_ptr_r;

    // in_ready looks only at the registered credit count, so a pop cannot
    // create room in the same cycle.
    assign bus.in_ready  = (cnt_r < CW'(Q_DEPTH));
    assign accept_s      = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (wr_ptr_r != rd_ptr_r);
    assign pop_s         = bus.out_valid & bus.out_ready;
    assign clear_s       = reset | bus.flush;
    assign bus.out_y     = q_y_r[rd_ptr_r[PW-1:0]];
    assign bus.out_tag   = q_tag_r[rd_ptr_r[PW-1:0]];

    assign eb_s    = bus.in_b[W-1] ^ bus.in_sub;
    assign fp_b_s  = {eb_s, bus.in_b[W-2:0]};
    assign a_nan_s = (&bus.in_a[W-2:FW]) & (|bus.in_a[FW-1:0]);
    assign b_nan_s = (&bus.in_b[W-2:FW]) & (|bus.in_b[FW-1:0]);
    assign a_inf_s = (&bus.in_a[W-2:FW]) & ~(|bus.in_a[FW-1:0]);
    assign b_inf_s = (&bus.in_b[W-2:FW]) & ~(|bus.in_b[FW-1:0]);

    // NaN/Inf result patch, decided at issue and carried down the tag pipe.
    always_comb begin
        spec_s = 1'b0;
        sval_s = {W{1'b0}};
        if (a_nan_s | b_nan_s) begin
            spec_s = 1'b1;
            sval_s = CNAN;
        end else if (a_inf_s & b_inf_s) begin
            spec_s = 1'b1;
            sval_s = (bus.in_a[W-1] != eb_s) ? CNAN : bus.in_a;
        end else if (a_inf_s) begin
            spec_s = 1'b1;
            sval_s = bus.in_a;
        end else if (b_inf_s) begin
            spec_s = 1'b1;
            sval_s = fp_b_s;
        end else begin
            spec_s = 1'b0;
            sval_s = {W{1'b0}};
        end
    end

    fp_add #(.W(W), .ADD_LAT(ADD_LAT)) u_fp_add (
        .clk   (clk),
        .reset (reset),
        .en    (accept_s),
        .a     (bus.in_a),
        .b     (fp_b_s),
        .y     (fp_y_s)
    );

    assign wr_s   = p_valid_r[ADD_LAT-1];
    assign wr_y_s = p_spec_r[ADD_LAT-1] ? p_sval_r[ADD_LAT-1] : fp_y_s;
    assign full_s = (wr_ptr_r[PW] != rd_ptr_r[PW])
                  && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);

    // Credit counter: in-flight plus queued ops; cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(accept_s) - CW'(pop_s);
        end
    end

    // In-flight valid pipe; clearing it drops every op still inside fp_add.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            p_valid_r <= {ADD_LAT{1'b0}};
        end else begin
            p_valid_r[0] <= accept_s;
            for (int i = 1; i < ADD_LAT; i++) begin
                p_valid_r[i] <= p_valid_r[i-1];
            end
        end
    end

    // Tag/patch payload pipe, qualified by the valid pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_tag_r  <= {(ADD_LAT*TAG_W){1'b0}};
            p_spec_r <= {ADD_LAT{1'b0}};
            p_sval_r <= {(ADD_LAT*W){1'b0}};
        end else begin
            p_tag_r[0]  <= bus.in_tag;
            p_spec_r[0] <= spec_s;
            p_sval_r[0] <= sval_s;
            for (int i = 1; i < ADD_LAT; i++) begin
                p_tag_r[i]  <= p_tag_r[i-1];
                p_spec_r[i] <= p_spec_r[i-1];
                p_sval_r[i] <= p_sval_r[i-1];
            end
        end
    end

    // Result FIFO: storage zeroed on reset only, pointers cleared on flush too.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {(PW+1){1'b0}};
            rd_ptr_r <= {(PW+1){1'b0}};
            for (int i = 0; i < Q_DEPTH; i++) begin
                q_y_r[i]   <= {W{1'b0}};
                q_tag_r[i] <= {TAG_W{1'b0}};
            end
        end else if (bus.flush) begin
            wr_ptr_r <= {(PW+1){1'b0}};
            rd_ptr_r <= {(PW+1){1'b0}};
        end else begin
            if (wr_s) begin
                q_y_r[wr_ptr_r[PW-1:0]]   <= wr_y_s;
                q_tag_r[wr_ptr_r[PW-1:0]] <= p_tag_r[ADD_LAT-1];
                wr_ptr_r                  <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    fp_add_issue_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .wr    (wr_s),
        .full  (full_s)
    );
endmodule

// File: tb/tb_fp_add_issue.sv
module tb_fp_add_issue;
    localparam int W       = 32;
    localparam int ADD_LAT = 2;
    localparam int TAG_W   = 6;
    localparam int Q_DEPTH = 4;
    localparam logic [31:0] CNAN = 32'h7fc0_0000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] y;
    } vec_t;

    typedef struct {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fp_add_issue_if #(.W(W), .TAG_W(TAG_W)) bus ();

    fp_add_issue #(.W(W), .ADD_LAT(ADD_LAT), .TAG_W(TAG_W), .Q_DEPTH(Q_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   sb_on = 1'b0;
    res_t exp_q[$];
    vec_t vecs[16];

    logic [31:0]      ry;
    logic [TAG_W-1:0] rtag;
    int               rlat, n_acc, popped, gaps, seen, guard;
    bit               first_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
    endfunction

    function automatic bit is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hff) && (x[22:0] == 23'd0);
    endfunction

    // Single -> double (normals and zeros; random stimulus stays in that set).
    function automatic real f2r(input logic [31:0] x);
        if (x[30:23] == 8'd0) return $bitstoreal({x[31], 63'd0});
        return $bitstoreal({x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0});
    endfunction

    // Double -> single with round-to-nearest-even (result assumed normal or zero).
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        logic [24:0] m;
        logic [28:0] rem;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e   = d[62:52] - 11'd896;
        m   = {2'b01, d[51:29]};
        rem = d[28:0];
        if ((rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 11'd1;
        end
        return {d[63], e[7:0], m[22:0]};
    endfunction

    // Reference: IEEE special rules first, otherwise exact double sum rounded to single.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [31:0] bb;
        bb = {b[31] ^ sub, b[30:0]};
        if (is_nan(a) || is_nan(b)) return CNAN;
        if (is_inf(a) && is_inf(bb)) return (a[31] != bb[31]) ? CNAN : a;
        if (is_inf(a)) return a;
        if (is_inf(bb)) return bb;
        return r2f(f2r(a) + f2r(bb));
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(15, 0);
        if (k == 0) return {r[31], 8'hff, 23'd0};
        if (k == 1) return {r[31], 8'hff, r[22:0] | 23'd1};
        return {r[31], 8'($urandom_range(150, 100)), r[22:0]};
    endfunction

    task automatic set_rand_op(input logic [TAG_W-1:0] tag);
        bus.in_a   = rnd_val();
        bus.in_b   = ($urandom_range(7, 0) == 0) ? bus.in_a : rnd_val();
        bus.in_sub = 1'($urandom);
        bus.in_tag = tag;
    endtask

    // One clock: scoreboard whatever handshakes complete at this edge.
    task automatic tick();
        res_t r;
        if (sb_on && !reset && !bus.flush) begin
            if (bus.in_valid && bus.in_ready) begin
                r.y   = ref_add(bus.in_a, bus.in_b, bus.in_sub);
                r.tag = bus.in_tag;
                exp_q.push_back(r);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pop_unexpected: got tag %0d with nothing expected", bus.out_tag);
                end else begin
                    r = exp_q.pop_front();
                    check("pop_y", 64'(bus.out_y), 64'(r.y));
                    check("pop_tag", 64'(bus.out_tag), 64'(r.tag));
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue a single op with out_ready=1 and measure cycles to out_valid.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic [TAG_W-1:0] tag, output logic [31:0] y,
                           output logic [TAG_W-1:0] tg, output int lat);
        int g;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_sub = sub;
        bus.in_tag = tag;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        g = 0;
        while (!bus.in_ready && g < 50) begin
            tick();
            g++;
        end
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        y  = bus.out_y;
        tg = bus.out_tag;
        tick();
    endtask

    initial begin
        vecs[0]  = '{32'h3f80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000};
        vecs[1]  = '{32'h4040_0000, 32'h4040_0000, 1'b1, 32'h0000_0000};
        vecs[2]  = '{32'h7fc0_0001, 32'h3f80_0000, 1'b0, 32'h7fc0_0000};
        vecs[3]  = '{32'h7f80_0000, 32'h7f80_0000, 1'b1, 32'h7fc0_0000};
        vecs[4]  = '{32'hff80_0000, 32'h3f80_0000, 1'b0, 32'hff80_0000};
        vecs[5]  = '{32'h3f80_0000, 32'h4000_0000, 1'b1, 32'hbf80_0000};
        vecs[6]  = '{32'h7f80_0000, 32'hff80_0000, 1'b0, 32'h7fc0_0000};
        vecs[7]  = '{32'h7f80_0000, 32'hff80_0000, 1'b1, 32'h7f80_0000};
        vecs[8]  = '{32'h3f80_0000, 32'h7f80_0000, 1'b1, 32'hff80_0000};
        vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000};
        vecs[10] = '{32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000};
        vecs[11] = '{32'h7f7f_ffff, 32'h7f7f_ffff, 1'b0, 32'h7f80_0000};
        vecs[12] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002};
        vecs[13] = '{32'h0080_0000, 32'h0000_0001, 1'b1, 32'h007f_ffff};
        vecs[14] = '{32'h3f80_0001, 32'h3380_0000, 1'b0, 32'h3f80_0002};
        vecs[15] = '{32'h3f80_0000, 32'h3380_0000, 1'b0, 32'h3f80_0000};

        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sub = 1'b0;
        bus.in_a = 32'd0;
        bus.in_b = 32'd0;
        bus.in_tag = 6'd0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_y", 64'(bus.out_y), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);

        // Directed vectors, each with exact latency.
        for (int i = 0; i < 16; i++) begin
            run_one(vecs[i].a, vecs[i].b, vecs[i].sub, TAG_W'(i), ry, rtag, rlat);
            check($sformatf("vec%0d_y", i), 64'(ry), 64'(vecs[i].y));
            check($sformatf("vec%0d_tag", i), 64'(rtag), 64'(i));
            check($sformatf("vec%0d_lat", i), 64'(rlat), 64'(ADD_LAT + 1));
        end
        sb_on = 1'b1;

        // Backpressure: exactly Q_DEPTH accepts, then in_ready stays low.
        bus.out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            set_rand_op(TAG_W'(n_acc));
            bus.in_valid = 1'b1;
            if (bus.in_ready) n_acc++;
            tick();
        end
        bus.in_valid = 1'b0;
        check("bp_accepts", 64'(n_acc), 64'(Q_DEPTH));
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        check("bp_ready_at_pop", 64'(bus.in_ready), 64'd0);
        tick();
        check("bp_ready_after_pop", 64'(bus.in_ready), 64'd1);
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Throughput: 64 back-to-back ops.
        popped = 0;
        gaps = 0;
        first_seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            set_rand_op(TAG_W'(i));
            bus.in_valid = 1'b1;
            check("tp_in_ready", 64'(bus.in_ready), 64'd1);
            if (bus.out_valid) begin
                first_seen = 1'b1;
                popped++;
            end else if (first_seen) begin
                gaps++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        guard = 0;
        while (popped < 64 && guard < 30) begin
            if (bus.out_valid) begin
                popped++;
            end else begin
                gaps++;
            end
            tick();
            guard++;
        end
        check("tp_results", 64'(popped), 64'd64);
        check("tp_gaps", 64'(gaps), 64'd0);

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            set_rand_op(TAG_W'(i));
            bus.in_valid = ($urandom_range(3, 0) != 0);
            bus.out_ready = ($urandom_range(9, 0) < 7);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 30) begin
            tick();
            guard++;
        end
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        // Reset (m=0) / flush (m=1) with ADD_LAT ops in flight and 2 queued.
        for (int m = 0; m < 2; m++) begin
            bus.out_ready = 1'b0;
            for (int i = 0; i < 2 + ADD_LAT; i++) begin
                set_rand_op(TAG_W'(40 + i));
                bus.in_valid = 1'b1;
                tick();
                if (i == 1) begin
                    bus.in_valid = 1'b0;
                    repeat (ADD_LAT + 1) tick();
                end
            end
            bus.in_valid = 1'b0;
            check($sformatf("mid%0d_queued", m), 64'(bus.out_valid), 64'd1);
            if (m == 0) reset = 1'b1;
            else bus.flush = 1'b1;
            tick();
            reset = 1'b0;
            bus.flush = 1'b0;
            exp_q.delete();
            check($sformatf("mid%0d_in_ready", m), 64'(bus.in_ready), 64'd1);
            check($sformatf("mid%0d_out_valid", m), 64'(bus.out_valid), 64'd0);
            if (m == 0) begin
                check("mid0_out_y", 64'(bus.out_y), 64'd0);
                check("mid0_out_tag", 64'(bus.out_tag), 64'd0);
            end
            bus.out_ready = 1'b1;
            seen = 0;
            repeat (ADD_LAT + 4) begin
                if (bus.out_valid) seen++;
                tick();
            end
            check($sformatf("mid%0d_no_stale", m), 64'(seen), 64'd0);
            run_one(32'h3f80_0000, 32'h4000_0000, 1'b0, 6'd9, ry, rtag, rlat);
            check($sformatf("mid%0d_next_y", m), 64'(ry), 64'h4040_0000);
            check($sformatf("mid%0d_next_tag", m), 64'(rtag), 64'd9);
            check($sformatf("mid%0d_next_lat", m), 64'(rlat), 64'(ADD_LAT + 1));
        end

        // Flush in the same cycle as an accept drops the op.
        set_rand_op(6'd33);
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        seen = 0;
        repeat (ADD_LAT + 4) begin
            if (bus.out_valid) seen++;
            tick();
        end
        check("flush_accept_dropped", 64'(seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
